// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared types and helpers for the GPIO register bank.
//   region_e   - address region decoded from addr[7:6]
//   W_*        - word indices inside the control region
//   be_mask()  - expands a 4-bit byte enable into a 32-bit bit mask
package gpio_bank_pkg;

  typedef enum logic [1:0] {
    REG_OUT = 2'd0,
    REG_SET = 2'd1,
    REG_CLR = 2'd2,
    REG_CTL = 2'd3
  } region_e;

  localparam logic [3:0] W_IN   = 4'd0;
  localparam logic [3:0] W_EN   = 4'd1;
  localparam logic [3:0] W_STAT = 4'd2;
  localparam logic [3:0] W_EDGE = 4'd3;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ctr_bus.sv
// CtrBus: handshake/response half of the peripheral bus.
//   req/we        - request and write flag (master to slave)
//   gnt           - grant (slave to master)
//   rvalid/rdata  - response valid and read data, one cycle after req
//   err           - error flag, valid with rvalid
interface CtrBus;
  logic        req;
  logic        we;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport Master (output req, we, input  gnt, rvalid, rdata, err);
  modport Slave  (input  req, we, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dat_bus.sv
// DatBus: address/data half of the peripheral bus.
//   addr  - byte address
//   be    - byte enables for wdata
//   wdata - write data
interface DatBus;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  modport Master (output addr, be, wdata);
  modport Slave  (input  addr, be, wdata);
endinterface

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: input conditioning for the GPIO bank.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   in_i          - asynchronous input pins
//   edge_sel_i    - per-bit edge select, 1 = rising, 0 = falling
//   sync_o        - synchronised input value
//   event_o       - one-cycle edge events, masked right after reset
module gpio_in_sync #(
  parameter int unsigned IW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [IW-1:0] in_i,
  input  logic [IW-1:0] edge_sel_i,
  output logic [IW-1:0] sync_o,
  output logic [IW-1:0] event_o
);

  logic [IW-1:0] sync1_q, sync1_d;
  logic [IW-1:0] sync2_q, sync2_d;
  logic [IW-1:0] prev_q, prev_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    sync1_d = in_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // Saturates at 3 once sync1, sync2 and prev all hold post-reset samples.
    cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
    sync_o  = sync2_q;
    event_o = '0;
    if (cnt_q == 2'd3) begin
      event_o = (sync2_q ^ prev_q) & ~(sync2_q ^ edge_sel_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: GPIO register bank on the DatBus/CtrBus slave port.
//   Clk, Rst_n - clock, asynchronous active-low reset
//   DatBus     - addr/be/wdata
//   CtrBus     - req/we in; gnt (= req), rvalid/rdata/err one cycle later
//   IO         - NOUT output words, word i on IO[32*i+31:32*i]
//   IN         - asynchronous input pins
//   Irq        - registered level interrupt, |(IRQ_STAT & IRQ_EN)
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned NOUT    = 3,
  parameter int unsigned IW      = 32,
  parameter logic [31:0] OUT_RST = 32'h0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  DatBus.Slave              DatBus,
  CtrBus.Slave              CtrBus,
  output logic [NOUT*32-1:0] IO,
  input  logic [IW-1:0]     IN,
  output logic              Irq
);

  region_e             region;
  logic [3:0]          word;
  logic                mapped, wr, rd;
  logic [31:0]         wmask, wbits, out_word, ctl_word;
  logic                unused_addr;

  logic [NOUT-1:0][31:0] out_q, out_d;
  logic [IW-1:0]       en_q, en_d, stat_q, stat_d, edge_q, edge_d;
  logic [IW-1:0]       sync, evt;
  logic                rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  gpio_in_sync #(
    .IW(IW)
  ) u_in_sync (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .in_i      (IN),
    .edge_sel_i(edge_q),
    .sync_o    (sync),
    .event_o   (evt)
  );

  assign unused_addr = ^{DatBus.addr[31:8], DatBus.addr[1:0]};

  // Decode and read mux
  always_comb begin
    region = region_e'(DatBus.addr[7:6]);
    word   = DatBus.addr[5:2];
    wmask  = be_mask(DatBus.be);
    wbits  = DatBus.wdata & wmask;
    mapped = (region == REG_CTL) ? (word < 4'd4) : (32'(word) < NOUT);
    wr     = CtrBus.req & CtrBus.we & mapped;
    rd     = CtrBus.req & ~CtrBus.we & mapped;

    out_word = '0;
    for (int i = 0; i < NOUT; i++) begin
      if (word == 4'(i)) out_word = out_q[i];
    end

    ctl_word = '0;
    case (word)
      W_IN:    ctl_word[IW-1:0] = sync;
      W_EN:    ctl_word[IW-1:0] = en_q;
      W_STAT:  ctl_word[IW-1:0] = stat_q;
      W_EDGE:  ctl_word[IW-1:0] = edge_q;
      default: ctl_word = '0;
    endcase
  end

  // Next state
  always_comb begin
    out_d  = out_q;
    en_d   = en_q;
    stat_d = stat_q;
    edge_d = edge_q;
    if (wr) begin
      unique case (region)
        REG_OUT, REG_SET, REG_CLR: begin
          for (int i = 0; i < NOUT; i++) begin
            if (word == 4'(i)) begin
              unique case (region)
                REG_OUT: out_d[i] = (out_q[i] & ~wmask) | wbits;
                REG_SET: out_d[i] = out_q[i] | wbits;
                default: out_d[i] = out_q[i] & ~wbits;
              endcase
            end
          end
        end
        REG_CTL: begin
          case (word)
            W_EN:    en_d   = (en_q & ~wmask[IW-1:0]) | wbits[IW-1:0];
            W_STAT:  stat_d = stat_q & ~wbits[IW-1:0];
            W_EDGE:  edge_d = (edge_q & ~wmask[IW-1:0]) | wbits[IW-1:0];
            default: ;
          endcase
        end
      endcase
    end
    // Applied after the W1C so a same-cycle event keeps the bit set.
    stat_d = stat_d | evt;
    irq_d  = |(stat_q & en_q);

    rvalid_d = CtrBus.req;
    err_d    = CtrBus.req & ~mapped;
    rdata_d  = '0;
    if (rd) rdata_d = (region == REG_CTL) ? ctl_word : out_word;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_q    <= {NOUT{OUT_RST}};
      en_q     <= '0;
      stat_q   <= '0;
      edge_q   <= '1;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      en_q     <= en_d;
      stat_q   <= stat_d;
      edge_q   <= edge_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign IO            = out_q;
  assign Irq           = irq_q;
  assign CtrBus.gnt    = CtrBus.req;
  assign CtrBus.rvalid = rvalid_q;
  assign CtrBus.rdata  = rdata_q;
  assign CtrBus.err    = err_q;

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised general-purpose I/O register bank on the DatBus/CtrBus peripheral slave port, succeeding the fixed three-word output module. It provides NOUT 32-bit output words with atomic set/clear aliases, and an IW-bit synchronised input port with per-bit edge detection. Edge events are latched into sticky status bits that drive a level interrupt. Unmapped addresses return an error response.

## Interface
Parameters:
- NOUT, 3: number of 32-bit output words, 1..16.
- IW, 32: input port width, 1..32.
- OUT_RST, 32'h0: reset value of every output word.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- DatBus  DatBus.Slave  –  addr, be, wdata.
- CtrBus  CtrBus.Slave  –  req, we, gnt, rvalid, rdata, err.
- IO  out  NOUT*32  output words; word i on IO[32*i+31:32*i].
- IN  in  IW  asynchronous input pins.
- Irq  out  1  level interrupt, registered.

## Operation
- Decode: region = addr[7:6], word = addr[5:2]. addr[1:0] and addr[31:8] are ignored.
- Region 0, OUT[word], word<NOUT: read/write with byte enables.
- Region 1, SET[word]: write ORs the byte-enabled wdata into OUT. Read returns OUT.
- Region 2, CLR[word]: write clears the OUT bits where byte-enabled wdata=1. Read returns OUT.
- Region 3 registers:
  - word 0, IN: read-only, synchronised input, zero-extended.
  - word 1, IRQ_EN: read/write, IW bits.
  - word 2, IRQ_STAT: reads status; writing 1 clears a bit.
  - word 3, EDGE_SEL: read/write, IW bits; 1=rising, 0=falling.
- Unmapped access: word≥NOUT in regions 0-2, or word≥4 in region 3. Writes are ignored, rdata=0, err=1.
- Input path:
  - 2-FF synchroniser, then a previous-value register.
  - Event when sync≠prev and sync equals the EDGE_SEL bit.
  - An event sets the matching IRQ_STAT bit regardless of IRQ_EN.
- Event masking: a 2-bit counter after reset masks events until both synchroniser stages and prev hold real samples, i.e. the first 3 cycles after Rst_n rises.
- Irq is registered |(IRQ_STAT & IRQ_EN), updated every cycle.
- Simultaneous event and W1C on the same bit: the set wins, so the bit stays 1.
- Bits above IW in region-3 registers read 0, and writes to them are ignored.

## Timing
- gnt = req, combinational. Every request is accepted in its cycle, back-to-back allowed.
- Writes take effect on the Clk edge ending the req cycle. IO changes the same edge.
- rvalid is asserted exactly one cycle after each req, for reads and writes. rdata and err are valid only while rvalid=1. err=0 on every mapped access.
- Read-after-write to the same word in consecutive cycles returns the new value.
- Input latency:
  - 2 cycles from an IN change to the IN register.
  - 3 cycles to IRQ_STAT.
  - 4 cycles to Irq, with IRQ_EN already set.
- Reset values:
  - IO=OUT_RST on every word; IRQ_EN=0; IRQ_STAT=0; EDGE_SEL=all 1s.
  - Synchroniser and prev registers=0; Irq=0.
  - rvalid=0, rdata=0, err=0.
- Reset mid-transaction: a pending rvalid is dropped and all state returns to its reset values.

## Structure
- Package gpio_bank_pkg:
  - region enum (REG_OUT, REG_SET, REG_CLR, REG_CTL);
  - region-3 word indices (W_IN, W_EN, W_STAT, W_EDGE);
  - function applying a 4-bit byte-enable mask to 32 bits.
- Sub-module gpio_in_sync(IW): synchroniser, prev register, edge select, startup mask. Outputs are the sync value and an IW-bit event vector.
- The top level holds the decode, OUT array, status/enable registers and the response register.

## Test plan
- Reset and readback:
  - Stimulus: reset with OUT_RST=32'hA5A5_0000, NOUT=3, then read 0x00, 0x04, 0x08.
  - Required: three A5A5_0000 reads, err=0, rvalid exactly 1 cycle after each req.
- Byte-enabled write and set/clear aliases:
  - Write 0x04 = 12345678 with be=4'b0101 → IO word 1 = 00340078.
  - SET 0x44 = FF000000 → FF340078.
  - CLR 0x84 = 00300008 → FF040070.
- Unmapped accesses:
  - Read 0x0C with NOUT=3 → rdata=0, err=1.
  - Write 0xD0 → err=1, no state changes.
  - The next read of 0x00 → err=0.
- Rising-edge interrupt:
  - Set IRQ_EN=1 and EDGE_SEL bit0=1, then drive IN[0] 0→1.
  - Required: IRQ_STAT=1 at 3 cycles, Irq=1 at 4 cycles.
  - Write 1 to 0xC8 → Irq=0 one cycle later.
  - With EDGE_SEL bit0=0, a 1→0 transition sets the bit and 0→1 does not.
- Simultaneous event and clear: an event on bit 2 in the same cycle as a W1C of bit 2 → IRQ_STAT[2]=1 afterwards.
- Reset mid-read and startup masking:
  - Drop Rst_n during a read's req cycle → no rvalid afterwards, IO=OUT_RST.
  - IN held high through reset release → no IRQ_STAT bit set.
